// File: rtl/sb_cfg_loader.sv
// sb_cfg_loader: serial configuration loader for a row of switch-box tiles.
// Hunts for SYNC_WORD (MSB first), shifts in NUM_SB*16 select bits LSB first,
// then checks one even-parity bit. The whole select bus is updated in one
// cycle only when the frame checks good.
// Optional build macro SB_SEL_LEGAL_CHECK_EN: also rejects frames that carry
// the unused 2'b11 code in any 2-bit select field.
module sb_cfg_loader #(
  parameter int         NUM_SB    = 1,
  parameter logic [7:0] SYNC_WORD = 8'hA5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cfg_bit,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic                   cfg_abort,
  output logic [NUM_SB*16-1:0]   sel_out,
  output logic                   cfg_done,
  output logic                   cfg_err,
  output logic                   busy
);

  localparam int PAY_W = NUM_SB * 16;
  localparam int CNT_W = $clog2(PAY_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PAY_W - 1);

  typedef enum logic [2:0] {
    ST_HUNT   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_PARITY = 3'd2,
    ST_COMMIT = 3'd3,
    ST_ERR    = 3'd4
  } state_e;

  // True when the ones count over payload plus parity bit is even.
  function automatic logic parity_even_ok(input logic [PAY_W-1:0] payload,
                                          input logic             par_bit);
    return ~(^payload ^ par_bit);
  endfunction

`ifdef SB_SEL_LEGAL_CHECK_EN
  // True when no 2-bit select field carries the unused code 2'b11.
  function automatic logic sel_fields_legal(input logic [PAY_W-1:0] payload);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < PAY_W / 2; i++) begin
      if (payload[2*i +: 2] == 2'b11) begin
        ok = 1'b0;
      end
    end
    return ok;
  endfunction
`endif

  state_e             state_q;
  logic [7:0]         sync_q;
  logic [PAY_W-1:0]   shadow_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [PAY_W-1:0]   sel_q;
  logic               done_q;
  logic               err_q;
  logic               busy_q;

  logic [7:0]         sync_d;
  logic [PAY_W-1:0]   shadow_d;
  logic               ready_s;
  logic               accept_s;
  logic               legal_s;
  logic               frame_ok_s;

  assign sync_d = {sync_q[6:0], cfg_bit};

`ifdef SB_SEL_LEGAL_CHECK_EN
  assign legal_s = sel_fields_legal(shadow_q);
`else
  assign legal_s = 1'b1;
`endif

  assign frame_ok_s = parity_even_ok(shadow_q, cfg_bit) && legal_s;

  // Shadow image with the incoming bit written at the current counter slot.
  always_comb begin
    shadow_d = shadow_q;
    for (int i = 0; i < PAY_W; i++) begin
      if (cnt_q == CNT_W'(i)) begin
        shadow_d[i] = cfg_bit;
      end else begin
        shadow_d[i] = shadow_q[i];
      end
    end
  end

  // Ready in the bit-accepting states, always withdrawn while abort is high.
  always_comb begin
    ready_s = 1'b0;
    if (cfg_abort) begin
      ready_s = 1'b0;
    end else begin
      case (state_q)
        ST_HUNT, ST_LOAD, ST_PARITY: ready_s = 1'b1;
        default:                     ready_s = 1'b0;
      endcase
    end
  end

  assign accept_s  = cfg_valid && ready_s;
  assign cfg_ready = ready_s;
  assign sel_out   = sel_q;
  assign cfg_done  = done_q;
  assign cfg_err   = err_q;
  assign busy      = busy_q;

  // Frame FSM with registered select bus and status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_HUNT;
      sync_q   <= 8'h00;
      shadow_q <= '0;
      cnt_q    <= '0;
      sel_q    <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (cfg_abort) begin
        // A commit already loaded sel_q on entry to COMMIT, so it survives.
        state_q  <= ST_HUNT;
        sync_q   <= 8'h00;
        shadow_q <= '0;
        cnt_q    <= '0;
        busy_q   <= 1'b0;
      end else begin
        case (state_q)
          ST_HUNT: begin
            if (accept_s) begin
              if (sync_d == SYNC_WORD) begin
                state_q <= ST_LOAD;
                sync_q  <= 8'h00;
                busy_q  <= 1'b1;
              end else begin
                sync_q <= sync_d;
              end
            end
          end
          ST_LOAD: begin
            if (accept_s) begin
              shadow_q <= shadow_d;
              cnt_q    <= cnt_q + CNT_W'(1);
              if (cnt_q == CNT_LAST) begin
                state_q <= ST_PARITY;
              end
            end
          end
          ST_PARITY: begin
            if (accept_s) begin
              if (frame_ok_s) begin
                sel_q   <= shadow_q;
                done_q  <= 1'b1;
                state_q <= ST_COMMIT;
              end else begin
                err_q   <= 1'b1;
                state_q <= ST_ERR;
              end
            end
          end
          ST_COMMIT, ST_ERR: begin
            state_q  <= ST_HUNT;
            shadow_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
          end
          default: begin
            state_q  <= ST_HUNT;
            sync_q   <= 8'h00;
            shadow_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/sb_cfg_loader.md
Name: sb_cfg_loader

Overview:
- Serial configuration loader sitting directly upstream of a row of switch-box tiles.
- Receives a framed configuration bitstream over a valid/ready bit interface and validates it.
- Drives each tile's 16-bit mux-select bus: 8 outputs per tile, 2 select bits per output, selecting 1 of 3 inputs.
- New select values are applied atomically: all tiles update in one cycle, only after the whole frame checks good.

Parameters:
- NUM_SB, 1, number of switch-box tiles driven; payload is NUM_SB*16 bits.
- SYNC_WORD, 8'hA5, frame start pattern.

Ports:
- clk  input  1  system clock, all logic on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- cfg_bit  input  1  serial config data bit.
- cfg_valid  input  1  cfg_bit is valid.
- cfg_ready  output  1  loader accepts a bit this cycle; transfer occurs when cfg_valid && cfg_ready.
- cfg_abort  input  1  discard the frame in progress and return to HUNT.
- sel_out  output  NUM_SB*16  active select buses; tile k uses bits [16k+15:16k].
- cfg_done  output  1  one-cycle pulse when a frame is committed.
- cfg_err  output  1  one-cycle pulse when a frame is rejected.
- busy  output  1  high in LOAD, PARITY, COMMIT and ERR.

Behaviour:
- Reset values (async, rst_n low):
  - sel_out = 0, cfg_done = 0, cfg_err = 0, busy = 0.
  - State = HUNT; shadow register, bit counter and sync shifter all cleared.
  - Reset mid-frame discards the partial frame completely.
- Frame format, in transfer order:
  - SYNC_WORD, MSB first.
  - NUM_SB*16 payload bits, LSB first: the first payload bit lands in sel_out[0], the last in sel_out[NUM_SB*16-1].
  - One even-parity bit: the count of ones over payload plus parity must be even.
- States:
  - HUNT: cfg_ready = 1. Each accepted bit shifts into an 8-bit sync shifter (new bit enters at LSB). When the shifter value including the current bit equals SYNC_WORD, go to LOAD on the next cycle. Overlapping patterns are allowed; there is no minimum bit count after reset beyond 8 bits.
  - LOAD: cfg_ready = 1. Each accepted bit is written to shadow[cnt] and cnt increments. When the bit at cnt = NUM_SB*16-1 is accepted, go to PARITY. The sync shifter is cleared on entry.
  - PARITY: cfg_ready = 1. On acceptance, compute parity over shadow plus the received bit.
    - Parity good (and legal, if the optional feature is enabled): go to COMMIT.
    - Otherwise: go to ERR.
  - COMMIT: cfg_ready = 0. sel_out <= shadow and cfg_done = 1 for this cycle. Go to HUNT next cycle.
  - ERR: cfg_ready = 0. cfg_err = 1 for this cycle; sel_out unchanged. Go to HUNT next cycle.
- Latency: parity bit accepted at edge N; sel_out is valid and cfg_done is high during cycle N+1; cfg_ready is high again at N+2.
- Flow control: the loader never stalls while cfg_ready is high. Any number of cycles with cfg_valid low between bits is allowed.
- cfg_abort:
  - Synchronous; takes effect in any state.
  - In HUNT it only clears the sync shifter.
  - cfg_ready = 0 while cfg_abort is high, so no bit is accepted that cycle.
  - Next state is HUNT; shadow and cnt are cleared and sel_out is held.
  - No cfg_err pulse is generated.
  - Abort during COMMIT does not cancel the commit in progress: that cycle's update and cfg_done still occur.
- Counter width is clog2(NUM_SB*16+1). The counter never wraps, because reaching the terminal count always exits LOAD.
- cfg_done and cfg_err are never high in the same cycle.

Optional Feature:
- Macro: SB_SEL_LEGAL_CHECK_EN.
- Defined: in the PARITY state, every 2-bit select field shadow[2i+1:2i] is checked. Any field equal to 2'b11 (an unused code for a 3-way mux) forces ERR, even with good parity.
- Undefined: no field check; 2'b11 codes are committed as-is.

Test Plan:
- NUM_SB=1; send A5, payload 16'h1214, parity 0 -> COMMIT cycle after the parity bit; sel_out = 16'h1214; cfg_done one-cycle pulse; cfg_ready low for exactly that cycle.
- Same frame but parity 1 -> cfg_err pulse, sel_out keeps its previous value (16'h0000 after reset), return to HUNT.
- Send garbage 1,0,1,1 then A5, payload 16'h1214, parity 0 -> sync found despite garbage; sel_out = 16'h1214.
- Valid A5 + 16'h0030 + parity 0 -> with SB_SEL_LEGAL_CHECK_EN: cfg_err, sel_out unchanged; without it: sel_out = 16'h0030, cfg_done.
- Assert rst_n low after A5 plus 7 payload bits -> all outputs 0, state HUNT; a subsequent full valid frame commits normally.
- Pulse cfg_abort mid-payload with cfg_valid high -> no bit accepted that cycle, no cfg_err, sel_out held; random cfg_valid gaps on the next full frame -> correct commit.
